// File: rtl/wb_ram_pkg.sv
// Shared types and helpers for the Wishbone RAM slave.
// Optional error termination is enabled by defining WB_RAM_ERR_EN.
package wb_ram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned WAIT_CNT_W = 4;

  // Expands one byte-lane select bit into its 8-bit data mask.
  function automatic logic [7:0] sel_to_mask(input logic sel_bit);
    return {8{sel_bit}};
  endfunction

endpackage

// File: rtl/wb_ram_byte_array.sv
// DEPTH x DATA_WIDTH synchronous RAM: one registered read port, one byte-enabled write port.
// No reset so the array maps onto block RAM.
module wb_ram_byte_array #(
  parameter int unsigned AW         = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM slave with configurable wait states and registered ack/data.
// Define WB_RAM_ERR_EN to terminate out-of-range accesses with err_o instead of ack_o.
module wb_ram_slave
  import wb_ram_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BE_WIDTH    = 4,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [BUS_WIDTH-1:0]  adr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   sel_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  tagn_o,
  input  logic                  tagn_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0]    adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [BE_WIDTH-1:0]     sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    tag_q, tag_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;

  logic                    req;
  logic                    go_resp;
  logic                    in_resp;
  logic                    adr_ok;
  logic                    resp_err;
  logic [DATA_WIDTH-1:0]   wmask;
  logic [BUS_WIDTH-1:0]    rd_adr;
  logic                    rd_en;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  assign req     = cyc_i & stb_i;
  assign in_resp = (state_q == StResp);
  assign adr_ok  = (32'(adr_q) < DEPTH);

`ifdef WB_RAM_ERR_EN
  assign resp_err = ~adr_ok;
`else
  assign resp_err = 1'b0;
`endif

  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < BE_WIDTH; b++) begin
      wmask[8*b +: 8] = sel_to_mask(sel_i[b]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    tag_d   = tag_q;
    go_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          adr_d  = adr_i;
          wdat_d = data_i & wmask;
          sel_d  = sel_i;
          we_d   = we_i;
          tag_d  = tagn_i;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            go_resp = 1'b1;
          end else begin
            cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StResp;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The RAM read is launched in the cycle before RESP; with no wait states that is
  // the sampling cycle itself, so the address comes straight from the bus.
  assign rd_adr = (state_q == StIdle) ? adr_i : adr_q;
  assign rd_en  = go_resp & ((state_q == StIdle) ? ~we_i : ~we_q);
  assign wr_en  = in_resp & we_q & adr_ok;

  always_comb begin
    ack_d  = in_resp & ~resp_err;
    err_d  = in_resp & resp_err;
    rdat_d = rdat_q;
    if (in_resp && !we_q && !resp_err) begin
      rdat_d = adr_ok ? ram_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      tag_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      tag_q   <= tag_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  wb_ram_byte_array #(
    .AW        (AW),
    .DATA_WIDTH(DATA_WIDTH),
    .BE_WIDTH  (BE_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk_i  (clk),
    .re_i   (rd_en),
    .raddr_i(AW'(rd_adr)),
    .rdata_o(ram_rdata),
    .we_i   (wr_en),
    .waddr_i(AW'(adr_q)),
    .be_i   (sel_q),
    .wdata_i(wdat_q)
  );

  assign data_o = rdat_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign tagn_o = tag_q;

endmodule
